// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the parametrised shift-and-add multiplier.
// Covers the SEQ_MULT_EARLY_DONE_EN build option used by seq_mult_ctrl / seq_mult_param.
package seq_mult_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Negation helper width; products of up to 64 bits (WIDTH <= 32) are supported.
    localparam int NEG_W = 64;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Two's-complement negation is width-independent in its low bits, so callers
    // zero-extend to NEG_W and keep only the slice they need.
    function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] v, input logic neg);
        return neg ? (~v + NEG_W'(1)) : v;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM for seq_mult_param: iteration counter, busy/done and datapath enables.
// With SEQ_MULT_EARLY_DONE_EN defined, RUN also exits once the multiplier runs out of set bits.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
`ifdef SEQ_MULT_EARLY_DONE_EN
    input  logic mplier_next_zero_i,
`endif
    output logic load_o,
    output logic step_o,
    output logic fin_o,
    output logic busy_o,
    output logic done_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             accept;
    logic             last_step;

    assign accept = start_i && (state_q == S_IDLE || state_q == S_DONE);

`ifdef SEQ_MULT_EARLY_DONE_EN
    assign last_step = (cnt_q == CNT_W'(1)) || mplier_next_zero_i;
`else
    assign last_step = (cnt_q == CNT_W'(1));
`endif

    // NOTE: every output of this block gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last_step) state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_RUN;
            cnt_d   = CNT_W'(WIDTH);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign load_o = accept;
    assign step_o = (state_q == S_RUN);
    assign fin_o  = (state_q == S_DONE);
    assign busy_o = (state_q == S_RUN);
    assign done_o = done_q;

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-and-add multiplier, unsigned or two's-complement.
// Define SEQ_MULT_EARLY_DONE_EN to end early when no multiplier bits remain.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int PW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [PW-1:0]    product
);

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [NEG_W-1:0] acc_signed;
    logic             load, step, fin;

    seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk                (clk),
        .rst                (rst),
        .start_i            (start),
`ifdef SEQ_MULT_EARLY_DONE_EN
        .mplier_next_zero_i (mplier_q[WIDTH-1:1] == '0),
`endif
        .load_o             (load),
        .step_o             (step),
        .fin_o              (fin),
        .busy_o             (busy),
        .done_o             (done)
    );

    // Magnitude of the most negative operand still fits unsigned in WIDTH bits.
    assign a_mag = (mode_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (mode_signed && b[WIDTH-1]) ? -b : b;

    assign acc_signed = cond_neg(NEG_W'(acc_q), neg_q);

    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;
        if (fin) product_d = acc_signed[PW-1:0];
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            neg_d    = mode_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param (WIDTH=16), fixed or SEQ_MULT_EARLY_DONE_EN build.
module tb_seq_mult_param;

    localparam int W = 16;
`ifdef SEQ_MULT_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
        int             busy;
    } exp_t;

    typedef struct {
        bit             s;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
        int             run_e;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           mode_signed;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];

    seq_mult_param #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode_signed (mode_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int run_e);
        return EARLY ? run_e + 1 : W + 1;
    endfunction

    // Called just after a falling edge; returns 1 ns after the accepting edge.
    task automatic issue(input bit s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2*W-1:0] ep, input int lat, input bit push);
        exp_t e;
        mode_signed = s;
        a           = av;
        b           = bv;
        start       = 1'b1;
        if (push) begin
            e.prod = ep;
            e.due  = cyc + 1 + lat;
            e.busy = lat - 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start       = 1'b0;
        a           = W'($urandom);
        b           = W'($urandom);
        mode_signed = 1'($urandom);
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("product", 64'(product), 64'(mon_e.prod));
                    check("done_cycle", 64'(cyc), 64'(mon_e.due));
                    check("busy_cycles", 64'(busy_cnt), 64'(mon_e.busy));
                end
                busy_cnt = 0;
            end
            if (busy) busy_cnt++;
        end
    end

    initial begin
        vecs[0] = '{1'b0, 16'd17,   16'd5,    32'd85,         3};
        vecs[1] = '{1'b1, 16'hFFFD, 16'd7,    32'hFFFF_FFEB,  3};
        vecs[2] = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 16};
        vecs[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16};
        vecs[4] = '{1'b0, 16'd9,    16'd1,    32'd9,          1};
        vecs[5] = '{1'b0, 16'h1234, 16'd0,    32'd0,          1};
        vecs[6] = '{1'b1, 16'd5,    16'hFFFF, 32'hFFFF_FFFB,  1};
        vecs[7] = '{1'b1, 16'h8000, 16'd1,    32'hFFFF_8000,  1};
        vecs[8] = '{1'b0, 16'h8000, 16'h8000, 32'h4000_0000, 16};
        vecs[9] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000, 16};

        rst         = 1'b1;
        start       = 1'b0;
        mode_signed = 1'b0;
        a           = '0;
        b           = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].p, lat_of(vecs[i].run_e), 1'b1);
            drain();
        end

        // A start while busy is ignored and the old product stays visible.
        @(negedge clk);
        issue(1'b0, 16'd100, 16'd255, 32'h0000_639C, lat_of(8), 1'b1);
        repeat (2) @(negedge clk);
        issue(1'b1, 16'd2, 16'hFFFE, 32'd0, 0, 1'b0);
        check("busy_mid_run", 64'(busy), 64'd1);
        check("product_held_in_run", 64'(product), 64'h0000_0000_C000_8000);

        // Back-to-back: a start in the done cycle is accepted.
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        check("wait_done", 64'(done), 64'd1);
        issue(1'b0, 16'd3, 16'd4, 32'd12, lat_of(3), 1'b1);
        drain();

        // Reset mid-RUN aborts without a done pulse.
        @(negedge clk);
        issue(1'b0, 16'd1000, 16'd1000, 32'h000F_4240, lat_of(10), 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("busy_before_abort", 64'(busy), 64'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_product", 64'(product), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_after_abort", 64'(busy), 64'd0);
        issue(1'b0, 16'd17, 16'd5, 32'd85, lat_of(3), 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
- Parametrised sequential shift-and-add multiplier. Successor to the 16-bit repeated-addition multiplier datapath/control pair.
- Takes two WIDTH-bit operands on a start pulse and produces a 2*WIDTH-bit product in a fixed, bounded number of cycles. Supports an unsigned mode and a two's-complement signed mode.
- Sits between a requesting controller and a consumer that waits on done.

Parameters:
- WIDTH, 16, operand width in bits; must be at least 2. Product width is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only when accepting (IDLE or DONE state)
- mode_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while the multiplication is in progress (RUN state)
- done  output  1  single-cycle pulse; product is valid from this cycle onward
- product  output  2*WIDTH  result; held until the next accepted start completes

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst).
  - Asserting rst forces state IDLE and clears busy, done, product, accumulator and counter.
  - rst takes effect immediately, including mid-RUN. The aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches the operands.
  - If mode_signed=1: latch |a| and |b|, and store neg = a[WIDTH-1] ^ b[WIDTH-1].
  - Otherwise latch a and b as-is and store neg = 0.
  - Clear the accumulator, load counter = WIDTH, go to RUN.
- RUN, on each edge:
  - If the multiplier LSB = 1, add the shifted multiplicand to the 2*WIDTH-bit accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1; decrement the counter.
  - When the counter reaches 0, go to DONE.
- DONE (one cycle):
  - product = neg ? -acc : acc, with 2*WIDTH-bit two's-complement negation.
  - done=1 for this cycle. Next state is IDLE.
  - start during DONE is accepted exactly as in IDLE, so back-to-back operation is allowed.
- Latency: with start sampled at edge N, done is high in the cycle following edge N+WIDTH+1.
- Arithmetic:
  - The magnitude of the most negative operand (2^(WIDTH-1)) fits unsigned in WIDTH bits.
  - The full 2*WIDTH-bit result never overflows in either mode.
- start while busy=1 is ignored. In-flight operands are unaffected.
- Operand inputs may change freely after the start cycle.
- product is not updated until DONE. Its previous value remains visible during RUN.

Optional Feature:
- Macro: SEQ_MULT_EARLY_DONE_EN.
- When defined:
  - RUN also exits to DONE on any edge where the shifted multiplier becomes 0 before the add.
  - Entering RUN with b = 0 goes to DONE after one RUN edge.
  - Latency is between 2 and WIDTH+1 edges; results are identical to fixed mode.
- When undefined:
  - Latency is always exactly WIDTH+1 edges.
  - No zero-detect logic is synthesised.

Decomposition:
- Package seq_mult_pkg holds:
  - state typedef (IDLE/RUN/DONE encoding);
  - localparam for the default width;
  - a function for 2*WIDTH-bit conditional negation.
- One natural sub-module: seq_mult_ctrl, containing the FSM, counter, busy/done generation and load/shift/add enables.
- Datapath registers (multiplicand, multiplier, accumulator, neg) stay in the top level, keeping the codebase's datapath/control split.

Test Plan:
- Unsigned: WIDTH=16, mode_signed=0, a=17, b=5, start for 1 cycle -> done after exactly 17 edges; product=85; busy high for 16 cycles.
- Signed: mode_signed=1, a=16'hFFFD (-3), b=7 -> product=32'hFFFFFFEB (-21).
- Signed extremes:
  - a=b=16'h8000 -> product=32'h40000000.
  - Unsigned a=b=16'hFFFF -> product=32'hFFFE0001.
- Handshake:
  - start pulsed again mid-RUN with different operands -> ignored; first result unchanged.
  - start held during DONE -> second operation begins; second done follows 17 edges later.
- Reset mid-op: assert rst at RUN edge 8 -> busy, done, product = 0 immediately; no done pulse; a new start afterwards computes correctly.
- With SEQ_MULT_EARLY_DONE_EN:
  - a=9, b=1 -> done after 2 edges, product=9.
  - b=0 -> product=0.
  - b=16'h8000 -> latency 17, matching fixed mode.
